soft_error_event_logger: RTL
============================

SOFT_ERROR_EVENT_LOGGER -- requirements
Module: soft_error_event_logger

Interface
REQ-001 Parameter ERRSIG_ID_num, default 7: number of bank error lines per channel.
REQ-002 Parameter FIFO_DEPTH, default 16: event FIFO entries, power of two, at least 2.
REQ-003 Parameter TS_WIDTH, default 32: timestamp counter width.
REQ-004 Parameter CNT_WIDTH, default 16: per-bank event counter width.
REQ-005 The block SHALL have one clock, i_clk, and an asynchronous active-low reset, i_rst_n.
REQ-006 Ports (name, direction, width, meaning) SHALL be as follows:
- i_clk, in, 1: system clock.
- i_rst_n, in, 1: async reset, active low.
- error_A, in, ERRSIG_ID_num: per-bank error flags from the error hub, channel A.
- error_B, in, ERRSIG_ID_num: per-bank error flags from the error hub, channel B.
- i_clear, in, 1: synchronous clear of counters and overflow.
- i_cnt_sel, in, 3: bank index for counter readout.
- o_cnt_A, out, CNT_WIDTH: channel A event count of the selected bank.
- o_cnt_B, out, CNT_WIDTH: channel B event count of the selected bank.
- o_evt_valid, out, 1: FIFO head event valid.
- i_evt_ready, in, 1: consumer accepts the head event.
- o_evt_data, out, EVT_W: head event word.
- o_overflow, out, 1: sticky flag; an event was dropped.

Function
REQ-007 The block SHALL register error_A and error_B into err_q each cycle, and SHALL hold the previous err_q in err_qq.
REQ-008 rise_A SHALL equal err_q_A & ~err_qq_A, and rise_B SHALL equal the same expression on channel B; an event exists when either rise vector is nonzero.
REQ-009 The event word SHALL be {rise_A, rise_B}, giving EVT_W = 2*ERRSIG_ID_num; with timestamps enabled it SHALL be {ts, rise_A, rise_B}.
REQ-010 Latency: an input rising before clock edge N SHALL be written at edge N+1, and o_evt_valid SHALL be high after edge N+1 if the FIFO was empty.
REQ-011 o_evt_valid SHALL equal FIFO not-empty.
REQ-012 o_evt_data SHALL stay stable while o_evt_valid & ~i_evt_ready.
REQ-013 A pop SHALL occur exactly when o_evt_valid & i_evt_ready.
REQ-014 When the FIFO is full and no pop occurs in the same cycle, an event SHALL be dropped and o_overflow SHALL set.
REQ-015 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-016 When the FIFO is empty, a push SHALL be accepted; ready without valid SHALL have no effect.
REQ-017 Counters SHALL increment by 1 per bank bit set in rise_A or rise_B, including dropped events, and SHALL saturate at all-ones.
REQ-018 i_clear SHALL zero all counters and o_overflow next cycle; a same-cycle rise SHALL leave that counter at 1.
REQ-019 i_clear SHALL NOT flush the FIFO.
REQ-020 When i_cnt_sel >= ERRSIG_ID_num, o_cnt_A and o_cnt_B SHALL read 0.
REQ-021 The counter readout SHALL be combinational from the counter registers.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-023 While i_rst_n is low, err_q, err_qq, the FIFO pointers, all counters, ts, o_overflow and o_evt_valid SHALL be 0.
REQ-024 An error held high across reset release SHALL produce exactly one event.
REQ-025 Reset asserted mid-transfer SHALL discard all queued events immediately.

Configuration
REQ-026 When SOFT_ERROR_TIMESTAMP_EN is defined, a free-running TS_WIDTH counter (wrapping, reset 0) SHALL be prepended to each event, holding the value at the cycle rise is computed.
REQ-027 When SOFT_ERROR_TIMESTAMP_EN is undefined, there SHALL be no timestamp counter, and EVT_W SHALL be 2*ERRSIG_ID_num.

Structure
REQ-028 Package soft_error_pkg SHALL hold ERRSIG_ID_num, the bank ID constants (BANK12=0 through BANK36=6), and the EVT_W function.
REQ-029 The FIFO SHALL be the sub-module soft_error_evt_fifo, a synchronous FIFO with full/empty, instantiated once.

Verification
REQ-030 Pulse error_A[2] high for 3 cycles with ready=1 -> one event, rise_A=7'b0000100, valid 2 cycles after the input; o_cnt_A (sel=2) reads 1.
REQ-031 Hold ready=0 and inject 17 distinct rises -> 16 queued, o_overflow=1, counters=17; draining returns events in order.
REQ-032 With the FIFO full, push and pop in the same cycle -> no drop, o_overflow stays 0, occupancy stays 16.
REQ-033 Preload the counter at all-ones, then rise -> counter stays all-ones; i_clear plus a same-cycle rise -> counter = 1.
REQ-034 Hold error_B[6]=1 through a reset release -> exactly one event, rise_B=7'b1000000.
REQ-035 Assert reset with 5 queued events -> o_evt_valid=0 immediately; with SOFT_ERROR_TIMESTAMP_EN, the first event after reset carries ts equal to the cycle count since release.

Source files
------------

// File: rtl/soft_error_pkg.sv
// Shared constants for the soft error event logger.
// SOFT_ERROR_TIMESTAMP_EN: when defined, each event word carries a timestamp
// prefix and the event width grows by the timestamp width.
package soft_error_pkg;

    localparam int ERRSIG_ID_num = 7;

    localparam int BANK12 = 0;
    localparam int BANK16 = 1;
    localparam int BANK20 = 2;
    localparam int BANK24 = 3;
    localparam int BANK28 = 4;
    localparam int BANK32 = 5;
    localparam int BANK36 = 6;

`ifdef SOFT_ERROR_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Width of one event word: both rise vectors, plus the timestamp when enabled
    function automatic int evt_w(input int n_banks, input int ts_width);
        return 2 * n_banks + (TS_EN ? ts_width : 0);
    endfunction

endpackage

// File: rtl/soft_error_evt_fifo.sv
// Synchronous event FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module soft_error_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance the read and write pointers; reset discards all queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage array needs no reset since the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/soft_error_event_logger.sv
// Soft error event logger: detects rising edges on per-bank error flags of
// two channels, queues one event word per cycle with any rise, keeps
// saturating per-bank counters and a sticky overflow flag.
// SOFT_ERROR_TIMESTAMP_EN: when defined, a free-running timestamp is
// prepended to each event word.
module soft_error_event_logger
    import soft_error_pkg::*;
#(
    parameter int ERRSIG_ID_num = soft_error_pkg::ERRSIG_ID_num,
    parameter int FIFO_DEPTH    = 16,
    parameter int TS_WIDTH      = 32,
    parameter int CNT_WIDTH     = 16,
    localparam int EVT_W        = evt_w(ERRSIG_ID_num, TS_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ERRSIG_ID_num-1:0] error_A,
    input  logic [ERRSIG_ID_num-1:0] error_B,
    input  logic                     i_clear,
    input  logic [2:0]               i_cnt_sel,
    output logic [CNT_WIDTH-1:0]     o_cnt_A,
    output logic [CNT_WIDTH-1:0]     o_cnt_B,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [EVT_W-1:0]         o_evt_data,
    output logic                     o_overflow
);

    logic [ERRSIG_ID_num-1:0] err_q_a;
    logic [ERRSIG_ID_num-1:0] err_q_b;
    logic [ERRSIG_ID_num-1:0] err_qq_a;
    logic [ERRSIG_ID_num-1:0] err_qq_b;
    logic [ERRSIG_ID_num-1:0] rise_a;
    logic [ERRSIG_ID_num-1:0] rise_b;
    logic [CNT_WIDTH-1:0]     cnt_a [ERRSIG_ID_num];
    logic [CNT_WIDTH-1:0]     cnt_b [ERRSIG_ID_num];
    logic [EVT_W-1:0]         evt_word;
    logic                     evt;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     drop;

    // Two-stage capture of the error flags; reset to zero so a flag held
    // high across reset release shows up as exactly one rise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q_a  <= '0;
            err_q_b  <= '0;
            err_qq_a <= '0;
            err_qq_b <= '0;
        end else begin
            err_q_a  <= error_A;
            err_q_b  <= error_B;
            err_qq_a <= err_q_a;
            err_qq_b <= err_q_b;
        end
    end

    assign rise_a = err_q_a & ~err_qq_a;
    assign rise_b = err_q_b & ~err_qq_b;
    assign evt    = (|rise_a) || (|rise_b);

`ifdef SOFT_ERROR_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    // Free-running wrapping timestamp sampled into each event word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    assign evt_word = {ts, rise_a, rise_b};
`else
    assign evt_word = {rise_a, rise_b};
`endif

    assign pop         = ~empty & i_evt_ready;
    assign drop        = evt & full & ~pop;
    assign o_evt_valid = ~empty;

    soft_error_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (evt),
        .pop   (pop),
        .wdata (evt_word),
        .rdata (o_evt_data),
        .full  (full),
        .empty (empty)
    );

    // Sticky overflow; a drop in the clearing cycle still leaves it set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_overflow <= drop;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

    // Saturating per-bank counters; dropped events are still counted and a
    // rise in the clearing cycle restarts its counter at one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ERRSIG_ID_num; i++) begin
                cnt_a[i] <= '0;
                cnt_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ERRSIG_ID_num; i++) begin
                if (i_clear) begin
                    cnt_a[i] <= CNT_WIDTH'(rise_a[i]);
                    cnt_b[i] <= CNT_WIDTH'(rise_b[i]);
                end else begin
                    if (rise_a[i] && (cnt_a[i] != '1)) begin
                        cnt_a[i] <= cnt_a[i] + CNT_WIDTH'(1);
                    end
                    if (rise_b[i] && (cnt_b[i] != '1)) begin
                        cnt_b[i] <= cnt_b[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Combinational counter readout; out-of-range bank selects read zero
    always_comb begin
        o_cnt_A = '0;
        o_cnt_B = '0;
        if (int'(i_cnt_sel) < ERRSIG_ID_num) begin
            o_cnt_A = cnt_a[i_cnt_sel];
            o_cnt_B = cnt_b[i_cnt_sel];
        end
    end

endmodule
